// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the SAP control sequencer.
//   - Opcode encodings (upper nibble of IR).
//   - T-state encodings T0..T4 (binary, 3 bits).
//   - Bit indices of the packed control word that the controller decodes
//     into individual strobes.
package sap_pkg;

  localparam int unsigned OpW     = 4;
  localparam int unsigned TStateW = 3;

  localparam logic [OpW-1:0] OP_LDA = 4'b0000;
  localparam logic [OpW-1:0] OP_ADD = 4'b0001;
  localparam logic [OpW-1:0] OP_SUB = 4'b0010;
  localparam logic [OpW-1:0] OP_STA = 4'b0100;
  localparam logic [OpW-1:0] OP_LDI = 4'b0101;
  localparam logic [OpW-1:0] OP_JMP = 4'b0110;
  localparam logic [OpW-1:0] OP_JC  = 4'b0111;
  localparam logic [OpW-1:0] OP_JZ  = 4'b1000;
  localparam logic [OpW-1:0] OP_OUT = 4'b1110;
  localparam logic [OpW-1:0] OP_HLT = 4'b1111;

  localparam logic [TStateW-1:0] T0 = 3'd0;
  localparam logic [TStateW-1:0] T1 = 3'd1;
  localparam logic [TStateW-1:0] T2 = 3'd2;
  localparam logic [TStateW-1:0] T3 = 3'd3;
  localparam logic [TStateW-1:0] T4 = 3'd4;

  // Control word bit positions
  localparam int unsigned CwPcOut   = 0;
  localparam int unsigned CwPcInc   = 1;
  localparam int unsigned CwJump    = 2;
  localparam int unsigned CwMarIn   = 3;
  localparam int unsigned CwRamOut  = 4;
  localparam int unsigned CwRamIn   = 5;
  localparam int unsigned CwIrIn    = 6;
  localparam int unsigned CwIrOut   = 7;
  localparam int unsigned CwAIn     = 8;
  localparam int unsigned CwAOut    = 9;
  localparam int unsigned CwBIn     = 10;
  localparam int unsigned CwAluOut  = 11;
  localparam int unsigned CwSub     = 12;
  localparam int unsigned CwFlagsIn = 13;
  localparam int unsigned CwOutIn   = 14;
  localparam int unsigned CwW       = 15;

  typedef logic [CwW-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_step_counter.sv
// sap_step_counter: T-state counter for the SAP sequencer.
//   clk_i      clock, posedge active
//   rst_ni     asynchronous active-low reset (counter -> T0)
//   restart_i  current step is the last one of the instruction; go to T0 next
//   freeze_i   hold the current T-state (halt)
//   t_state_o  current T-state, binary
// Freeze has priority over restart. The counter also wraps by itself after
// LastState so it can never leave the legal range.
module sap_step_counter
  import sap_pkg::*;
#(
  parameter int unsigned LastState = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               restart_i,
  input  logic               freeze_i,
  output logic [TStateW-1:0] t_state_o
);

  logic [TStateW-1:0] t_state_d, t_state_q;

  always_comb begin
    t_state_d = t_state_q;
    if (freeze_i) begin
      t_state_d = t_state_q;
    end else if (restart_i || (t_state_q >= TStateW'(LastState))) begin
      t_state_d = T0;
    end else begin
      t_state_d = t_state_q + TStateW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_state_q <= T0;
    end else begin
      t_state_q <= t_state_d;
    end
  end

  assign t_state_o = t_state_q;

endmodule

// File: rtl/sap_controller.sv
// sap_controller: control sequencer for the SAP CPU.
// Steps T0..T4, decodes ir_opcode and drives one-hot control strobes.
//   clock, reset_n        posedge clock, asynchronous active-low reset
//   ir_opcode             IR upper nibble, used from T2 onward
//   carry_flag/zero_flag  ALU flags (only used for JC/JZ)
//   pc_out..out_in        bus/register control strobes, combinational
//   hlt                   CPU halted
//   t_state               current T-state (debug)
// Build option: define COND_JUMP_EN to enable JC (0111) and JZ (1000);
// without it both decode as NOP and the flag inputs are ignored.
module sap_controller
  import sap_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned T_STATES = 5  // only 5 is meaningful
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                jump,
  output logic                mar_in,
  output logic                ram_out,
  output logic                ram_in,
  output logic                ir_in,
  output logic                ir_out,
  output logic                a_in,
  output logic                a_out,
  output logic                b_in,
  output logic                alu_out,
  output logic                sub,
  output logic                flags_in,
  output logic                out_in,
  output logic                hlt,
  output logic [2:0]          t_state
);

  logic               halted_d, halted_q;
  logic               halt_set;
  logic               restart;
  logic [TStateW-1:0] t_state_cur;
  ctrl_word_t         cw;
  ctrl_word_t         cw_gated;

`ifndef COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = carry_flag ^ zero_flag;
`endif

  sap_step_counter #(
    .LastState (T_STATES - 1)
  ) u_step_counter (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .restart_i (restart),
    .freeze_i  (halted_q | halt_set),
    .t_state_o (t_state_cur)
  );

  always_comb begin
    cw       = '0;
    restart  = 1'b0;
    halt_set = 1'b0;
    unique case (t_state_cur)
      T0: begin
        cw[CwPcOut] = 1'b1;
        cw[CwMarIn] = 1'b1;
      end
      T1: begin
        cw[CwRamOut] = 1'b1;
        cw[CwIrIn]   = 1'b1;
        cw[CwPcInc]  = 1'b1;
      end
      T2: begin
        restart = 1'b1;
        case (ir_opcode)
          OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_STA): begin
            cw[CwIrOut] = 1'b1;
            cw[CwMarIn] = 1'b1;
            restart     = 1'b0;
          end
          OPCODE_W'(OP_LDI): begin
            cw[CwIrOut] = 1'b1;
            cw[CwAIn]   = 1'b1;
          end
          OPCODE_W'(OP_JMP): begin
            cw[CwIrOut] = 1'b1;
            cw[CwJump]  = 1'b1;
          end
`ifdef COND_JUMP_EN
          OPCODE_W'(OP_JC): begin
            cw[CwIrOut] = carry_flag;
            cw[CwJump]  = carry_flag;
          end
          OPCODE_W'(OP_JZ): begin
            cw[CwIrOut] = zero_flag;
            cw[CwJump]  = zero_flag;
          end
`endif
          OPCODE_W'(OP_OUT): begin
            cw[CwAOut]  = 1'b1;
            cw[CwOutIn] = 1'b1;
          end
          OPCODE_W'(OP_HLT): begin
            halt_set = 1'b1;
            restart  = 1'b0;
          end
          default: ;  // NOP
        endcase
      end
      T3: begin
        restart = 1'b1;
        case (ir_opcode)
          OPCODE_W'(OP_LDA): begin
            cw[CwRamOut] = 1'b1;
            cw[CwAIn]    = 1'b1;
          end
          OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
            cw[CwRamOut] = 1'b1;
            cw[CwBIn]    = 1'b1;
            restart      = 1'b0;
          end
          OPCODE_W'(OP_STA): begin
            cw[CwAOut]  = 1'b1;
            cw[CwRamIn] = 1'b1;
          end
          default: ;  // only reachable if the opcode changed mid-instruction
        endcase
      end
      T4: begin
        restart = 1'b1;
        if (ir_opcode == OPCODE_W'(OP_ADD) || ir_opcode == OPCODE_W'(OP_SUB)) begin
          cw[CwAluOut]  = 1'b1;
          cw[CwAIn]     = 1'b1;
          cw[CwFlagsIn] = 1'b1;
          cw[CwSub]     = (ir_opcode == OPCODE_W'(OP_SUB));
        end
      end
      default: restart = 1'b1;
    endcase
  end

  // Strobes must be quiet the instant reset asserts, not at the next edge.
  assign cw_gated = (reset_n && !halted_q) ? cw : '0;
  assign halted_d = halted_q | halt_set;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign pc_out   = cw_gated[CwPcOut];
  assign pc_inc   = cw_gated[CwPcInc];
  assign jump     = cw_gated[CwJump];
  assign mar_in   = cw_gated[CwMarIn];
  assign ram_out  = cw_gated[CwRamOut];
  assign ram_in   = cw_gated[CwRamIn];
  assign ir_in    = cw_gated[CwIrIn];
  assign ir_out   = cw_gated[CwIrOut];
  assign a_in     = cw_gated[CwAIn];
  assign a_out    = cw_gated[CwAOut];
  assign b_in     = cw_gated[CwBIn];
  assign alu_out  = cw_gated[CwAluOut];
  assign sub      = cw_gated[CwSub];
  assign flags_in = cw_gated[CwFlagsIn];
  assign out_in   = cw_gated[CwOutIn];
  assign hlt      = reset_n & (halted_q | halt_set);
  assign t_state  = t_state_cur;

endmodule

// File: tb/tb_sap_controller.sv
// Testbench for sap_controller: directed sequences plus randomized opcodes,
// checked every negedge against an instruction-level model.
module tb_sap_controller;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] ir_opcode = 4'h0;
  logic       carry_flag = 1'b0;
  logic       zero_flag  = 1'b0;
  logic pc_out, pc_inc, jump, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic a_in, a_out, b_in, alu_out, sub, flags_in, out_in, hlt;
  logic [2:0] t_state;

  int errors = 0;
  int checks = 0;
  bit rand_flags = 1'b0;

  always #5 clock = ~clock;

  sap_controller u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ir_opcode  (ir_opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .pc_out     (pc_out),
    .pc_inc     (pc_inc),
    .jump       (jump),
    .mar_in     (mar_in),
    .ram_out    (ram_out),
    .ram_in     (ram_in),
    .ir_in      (ir_in),
    .ir_out     (ir_out),
    .a_in       (a_in),
    .a_out      (a_out),
    .b_in       (b_in),
    .alu_out    (alu_out),
    .sub        (sub),
    .flags_in   (flags_in),
    .out_in     (out_in),
    .hlt        (hlt),
    .t_state    (t_state)
  );

  // Bench-local strobe masks
  localparam logic [14:0] M_PC_OUT = 15'h0001;
  localparam logic [14:0] M_PC_INC = 15'h0002;
  localparam logic [14:0] M_JUMP   = 15'h0004;
  localparam logic [14:0] M_MAR_IN = 15'h0008;
  localparam logic [14:0] M_RAM_OUT= 15'h0010;
  localparam logic [14:0] M_RAM_IN = 15'h0020;
  localparam logic [14:0] M_IR_IN  = 15'h0040;
  localparam logic [14:0] M_IR_OUT = 15'h0080;
  localparam logic [14:0] M_A_IN   = 15'h0100;
  localparam logic [14:0] M_A_OUT  = 15'h0200;
  localparam logic [14:0] M_B_IN   = 15'h0400;
  localparam logic [14:0] M_ALU_OUT= 15'h0800;
  localparam logic [14:0] M_SUB    = 15'h1000;
  localparam logic [14:0] M_FLAGS  = 15'h2000;
  localparam logic [14:0] M_OUT_IN = 15'h4000;

  logic [14:0] dut_cw;
  assign dut_cw = {out_in, flags_in, sub, alu_out, b_in, a_out, a_in, ir_out, ir_in,
                   ram_in, ram_out, mar_in, jump, pc_inc, pc_out};

  logic [4:0] drivers;
  assign drivers = {pc_out, ram_out, ir_out, a_out, alu_out};

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of T-states an instruction occupies (HLT never completes).
  function automatic int inst_len(input logic [3:0] op);
    case (op)
      4'h0, 4'h4: return 4;
      4'h1, 4'h2: return 5;
      default:    return 3;
    endcase
  endfunction

  // Microcode table: strobes for a running (non-halted) instruction at a step.
  function automatic logic [14:0] exp_cw(input logic [3:0] op, input int step,
                                         input logic c, input logic z);
    logic [14:0] w;
    w = '0;
    if (step == 0) return M_PC_OUT | M_MAR_IN;
    if (step == 1) return M_RAM_OUT | M_IR_IN | M_PC_INC;
    case (op)
      4'h0: w = (step == 2) ? (M_IR_OUT | M_MAR_IN) : (step == 3) ? (M_RAM_OUT | M_A_IN) : '0;
      4'h1, 4'h2: begin
        if (step == 2) w = M_IR_OUT | M_MAR_IN;
        if (step == 3) w = M_RAM_OUT | M_B_IN;
        if (step == 4) w = M_ALU_OUT | M_A_IN | M_FLAGS | ((op == 4'h2) ? M_SUB : '0);
      end
      4'h4: w = (step == 2) ? (M_IR_OUT | M_MAR_IN) : (step == 3) ? (M_A_OUT | M_RAM_IN) : '0;
      4'h5: w = M_IR_OUT | M_A_IN;
      4'h6: w = M_IR_OUT | M_JUMP;
      4'hE: w = M_A_OUT | M_OUT_IN;
`ifdef COND_JUMP_EN
      4'h7: w = c ? (M_IR_OUT | M_JUMP) : '0;
      4'h8: w = z ? (M_IR_OUT | M_JUMP) : '0;
`endif
      default: w = '0;
    endcase
    return w;
  endfunction

  // Instruction-level model state
  int m_step   = 0;
  bit m_halted = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_step   <= 0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (m_step == 2 && ir_opcode == 4'hF) m_halted <= 1'b1;
      else if (m_step == inst_len(ir_opcode) - 1) m_step <= 0;
      else m_step <= m_step + 1;
    end
  end

  // Every-cycle comparison
  always @(negedge clock) begin
    logic [14:0] e_cw;
    int          e_t;
    bit          e_hlt;
    if (!reset_n) begin
      e_cw = '0; e_t = 0; e_hlt = 1'b0;
    end else if (m_halted) begin
      e_cw = '0; e_t = 2; e_hlt = 1'b1;
    end else if (m_step == 2 && ir_opcode == 4'hF) begin
      e_cw = '0; e_t = 2; e_hlt = 1'b1;
    end else begin
      e_cw = exp_cw(ir_opcode, m_step, carry_flag, zero_flag);
      e_t = m_step; e_hlt = 1'b0;
    end
    check("cw", dut_cw, e_cw);
    check("t_state", t_state, e_t);
    check("hlt", hlt, e_hlt);
    check("one_bus_driver", ($countones(drivers) <= 1), 1);
    check("t_state_range", (t_state <= 3'd4), 1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_flags) begin
      carry_flag = 1'($urandom);
      zero_flag  = 1'($urandom);
    end
  endtask

  task automatic reset_pulse();
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    ir_opcode = 4'h5;
    #11;  // t=12, between edges
    check("reset_cw", dut_cw, 0);
    check("reset_hlt", hlt, 0);
    #1 reset_n = 1'b1;
    #1;
    check("ldi_t0", dut_cw, M_PC_OUT | M_MAR_IN);
    tick();
    check("ldi_t1", dut_cw, M_RAM_OUT | M_IR_IN | M_PC_INC);
    tick();
    check("ldi_t2", dut_cw, M_IR_OUT | M_A_IN);
    tick();
    check("ldi_end_t", t_state, 0);

    // ADD then SUB: full five-step walk
    for (int k = 0; k < 2; k++) begin
      ir_opcode = (k == 0) ? 4'h1 : 4'h2;
      for (int s = 0; s < 5; s++) begin
        check("addsub_t", t_state, s);
        check("addsub_flags", flags_in, (s == 4));
        check("addsub_alu", alu_out, (s == 4));
        check("addsub_sub", sub, (k == 1 && s == 4));
        tick();
      end
      check("addsub_wrap", t_state, 0);
    end

    // HLT
    ir_opcode = 4'hF;
    tick(); tick();
    check("hlt_at_t2", hlt, 1);
    check("hlt_t2_cw", dut_cw, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hlt_frozen_t", t_state, 2);
      check("hlt_frozen_cw", dut_cw, 0);
      check("hlt_held", hlt, 1);
    end
    #1 reset_n = 1'b0;
    #1;
    check("hlt_cleared", hlt, 0);
    check("hlt_reset_t", t_state, 0);
    reset_n = 1'b1;

    // Reset in the middle of ADD at T3
    ir_opcode = 4'h1;
    tick(); tick(); tick();
    check("midadd_t3", t_state, 3);
    #1 reset_n = 1'b0;
    #1;
    check("midadd_cw", dut_cw, 0);
    check("midadd_t", t_state, 0);
    check("midadd_hlt", hlt, 0);
    #1 reset_n = 1'b1;
    #1;
    check("midadd_refetch", dut_cw, M_PC_OUT | M_MAR_IN);
    tick();
    check("midadd_t1", t_state, 1);
    tick();
    tick(); tick(); tick();  // finish the ADD

    // JZ with both flag values
    ir_opcode = 4'h8;
    zero_flag = 1'b1;
    tick(); tick();
`ifdef COND_JUMP_EN
    check("jz_taken", dut_cw, M_IR_OUT | M_JUMP);
`else
    check("jz_nop_1", dut_cw, 0);
`endif
    tick();
    check("jz_end", t_state, 0);
    zero_flag = 1'b0;
    tick(); tick();
    check("jz_not_taken", dut_cw, 0);
    tick();

    // Random instruction stream
    rand_flags = 1'b1;
    for (int n = 0; n < 400; n++) begin
      ir_opcode = 4'($urandom_range(0, 15));
      if (ir_opcode == 4'hF) begin
        for (int i = 0; i < 2 + int'($urandom_range(0, 4)); i++) tick();
        reset_pulse();
      end else begin
        int budget;
        budget = 8;
        tick();
        while (m_step != 0 && budget > 0) begin
          tick();
          budget--;
        end
        if (budget == 0) check("inst_timeout", 0, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
